julia_frame_scanner: RTL and testbench

- Frame-level initiator for the per-pixel Julia calculation engine. Walks every pixel of an H_RES x V_RES frame and generates each pixel's fixed-point complex coordinate.
- Per pixel: drives the engine's load/run handshake, collects the 16-bit colour, and writes it to the frame buffer through a ready/valid write port.
- Sits between the frame-start control and the calc engine / VRAM writer.

---
 rtl/julia_frame_scanner.sv | 154 +++++++++++++++
 tb/tb_julia_frame_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_frame_scanner.sv
// Frame scanner: walks every pixel of an H_RES x V_RES frame, hands each pixel's
// complex coordinate to the Julia engine and writes the resulting colour to VRAM.
module julia_frame_scanner #(
  parameter int          H_RES         = 640,
  parameter int          V_RES         = 480,
  parameter int          ADDR_W        = 19,
  parameter int          TIMEOUT       = 65536,
  parameter logic [15:0] TIMEOUT_COLOR = 16'h001F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       x_origin,
  input  logic [31:0]       y_origin,
  input  logic [31:0]       step_x,
  input  logic [31:0]       step_y,
  output logic              busy,
  output logic              done,
  output logic              calc_enable,
  output logic [31:0]       calc_x,
  output logic [31:0]       calc_y,
  input  logic              calc_end,
  input  logic [15:0]       calc_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  input  logic              wr_ready
);

  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      x_org, stp_x, stp_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [WD_W-1:0]  wd;

  logic busy_d, done_d, en_d, wr_en_d;

  // wd is zero only on the first RUN cycle, so it doubles as the stale-result guard
  logic run_hit, run_to, xfer, last_col, last_row;
  assign run_hit  = calc_end && (wd != '0);
  assign run_to   = (wd == WD_W'(TIMEOUT - 1));
  assign xfer     = wr_en && wr_ready;
  assign last_col = (col == COL_W'(H_RES - 1));
  assign last_row = (row == ROW_W'(V_RES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                  state_d = S_IDLE;
        else if (run_hit || run_to) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (abort)     state_d = S_IDLE;
        else if (xfer) state_d = (last_col && last_row) ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are decoded from the next state and registered
  always_comb begin
    busy_d  = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    en_d    = (state_d == S_RUN);
    wr_en_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      calc_enable <= 1'b0;
      wr_en       <= 1'b0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      calc_enable <= en_d;
      wr_en       <= wr_en_d;
    end
  end

  // calc_x/calc_y are the current-pixel coordinate registers; wr_addr/wr_data
  // are the pixel address and captured colour, so they hold through backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_org   <= '0;
      stp_x   <= '0;
      stp_y   <= '0;
      calc_x  <= '0;
      calc_y  <= '0;
      col     <= '0;
      row     <= '0;
      wd      <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          x_org   <= x_origin;
          stp_x   <= step_x;
          stp_y   <= step_y;
          calc_x  <= x_origin;
          calc_y  <= y_origin;
          col     <= '0;
          row     <= '0;
          wr_addr <= '0;
        end
        S_LOAD: wd <= '0;
        S_RUN: begin
          wd <= wd + WD_W'(1);
          if (run_hit)     wr_data <= calc_color;
          else if (run_to) wr_data <= TIMEOUT_COLOR;
        end
        S_WRITE: if (xfer) begin
          wr_addr <= wr_addr + ADDR_W'(1);
          if (last_col) begin
            col    <= '0;
            row    <= row + ROW_W'(1);
            calc_x <= x_org;
            calc_y <= calc_y - stp_y;
          end else begin
            col    <= col + COL_W'(1);
            calc_x <= calc_x + stp_x;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_frame_scanner.sv
// Directed bench for julia_frame_scanner on a 4x3 frame with a reactive engine model.
module tb_julia_frame_scanner;

  localparam int H = 4, V = 3, AW = 4, TO = 16;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0]   x_origin = '0, y_origin = '0, step_x = '0, step_y = '0;
  logic          busy, done, calc_enable, calc_end, wr_en, wr_ready = 1'b1;
  logic [31:0]   calc_x, calc_y;
  logic [15:0]   calc_color, wr_data;
  logic [AW-1:0] wr_addr;

  int checks = 0, errors = 0;

  julia_frame_scanner #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .TIMEOUT(TO),
                        .TIMEOUT_COLOR(16'h001F)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .x_origin(x_origin), .y_origin(y_origin), .step_x(step_x), .step_y(step_y),
    .busy(busy), .done(done), .calc_enable(calc_enable),
    .calc_x(calc_x), .calc_y(calc_y), .calc_end(calc_end), .calc_color(calc_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready));

  always #5 clk = ~clk;

  // Engine model: result on the 3rd RUN cycle, colour A000+pixel index;
  // hang_pix never finishes, stale adds a bogus result on the 1st RUN cycle.
  int       hang_pix = -1;
  bit       stale = 1'b0;
  logic [7:0] run_cnt;
  logic     prev_en;
  int       model_pix;
  int       rlen [64];

  assign calc_end = calc_enable && (model_pix != hang_pix) &&
                    ((run_cnt >= 8'd2) || (stale && run_cnt == 8'd0));
  assign calc_color = 16'hA000 + 16'(model_pix);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0; prev_en <= 1'b0; model_pix <= 0;
    end else begin
      prev_en <= calc_enable;
      run_cnt <= calc_enable ? run_cnt + 8'd1 : 8'd0;
      if (start && !busy) model_pix <= 0;
      else if (prev_en && !calc_enable) begin
        if (model_pix < 64) rlen[model_pix] <= 32'(run_cnt);
        model_pix <= model_pix + 1;
      end
    end
  end

  // Logs of accepted writes, LOAD-cycle coordinates and done pulses
  int nw = 0, nl = 0, ndone = 0;
  logic [AW-1:0] wa [256];
  logic [15:0]   wdat [256];
  logic [31:0]   cx [256], cy [256];

  always @(posedge clk) begin
    if (wr_en && wr_ready && nw < 256) begin wa[nw] = wr_addr; wdat[nw] = wr_data; nw++; end
    if (busy && !calc_enable && !wr_en && nl < 256) begin cx[nl] = calc_x; cy[nl] = calc_y; nl++; end
    if (done) ndone++;
  end

  task automatic set_frame();
    x_origin = 32'hFE000000; y_origin = 32'h01000000;
    step_x = 32'h00800000; step_y = 32'h00800000;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_writes(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (nw >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_sig(input bit want_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (want_wr ? wr_en : calc_enable) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (calc_enable !== 1'b0) begin errors++; $display("FAIL reset_calc_enable got %0b want 0", calc_enable); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr got %0h want 0", wr_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got %0h want 0", wr_data); end
    checks++; if (calc_x !== 32'h0 || calc_y !== 32'h0) begin errors++; $display("FAIL reset_coord got %0h/%0h want 0/0", calc_x, calc_y); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_scan();
    int bw, bl, bd; bit ok;
    set_frame(); wr_ready = 1'b1;
    bw = nw; bl = nl; bd = ndone;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got none want done"); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_after busy=%0b done=%0b want 0/0", busy, done); end
    checks++; if (ndone - bd != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", ndone - bd); end
    checks++; if (nw - bw != 12 || nl - bl != 12) begin errors++; $display("FAIL basic_counts writes=%0d loads=%0d want 12/12", nw - bw, nl - bl); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (wa[bw+i] !== AW'(i) || wdat[bw+i] !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL basic_write%0d got %0h/%0h want %0h/%0h", i, wa[bw+i], wdat[bw+i], i, 16'hA000 + 16'(i));
      end
    end
    checks++; if (cx[bl+3] !== 32'hFF800000 || cy[bl+3] !== 32'h01000000) begin errors++; $display("FAIL basic_px30 got %0h/%0h want ff800000/01000000", cx[bl+3], cy[bl+3]); end
    checks++; if (cx[bl+8] !== 32'hFE000000 || cy[bl+8] !== 32'h00000000) begin errors++; $display("FAIL basic_px02 got %0h/%0h want fe000000/0", cx[bl+8], cy[bl+8]); end
    checks++; if (rlen[3] != 3) begin errors++; $display("FAIL basic_run_len got %0d want 3", rlen[3]); end
  endtask

  task automatic test_backpressure();
    int bw, bl; bit ok;
    bw = nw; bl = nl;
    pulse_start();
    wait_writes(bw + 6, ok);
    wr_ready = 1'b0;
    wait_sig(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_wr_en_timeout got none want wr_en"); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(6) || wr_data !== 16'hA006 || calc_enable !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got en=%0b addr=%0h data=%0h run=%0b want 1/6/a006/0", k, wr_en, wr_addr, wr_data, calc_enable);
      end
      @(negedge clk);
    end
    checks++; if (nw - bw != 6 || nl - bl != 7) begin errors++; $display("FAIL bp_stalled writes=%0d loads=%0d want 6/7", nw - bw, nl - bl); end
    wr_ready = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got none want done"); end
    checks++; if (nw - bw != 12 || wa[bw+6] !== AW'(6) || wa[bw+7] !== AW'(7) || wdat[bw+7] !== 16'hA007) begin
      errors++; $display("FAIL bp_resume n=%0d a6=%0h a7=%0h d7=%0h want 12/6/7/a007", nw - bw, wa[bw+6], wa[bw+7], wdat[bw+7]);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int bw; bit ok;
    bw = nw; hang_pix = 5;
    pulse_start();
    wait_done(ok);
    hang_pix = -1;
    checks++; if (!ok) begin errors++; $display("FAIL to_done_timeout got none want done"); end
    checks++; if (wa[bw+5] !== AW'(5) || wdat[bw+5] !== 16'h001F) begin errors++; $display("FAIL to_write got %0h/%0h want 5/001f", wa[bw+5], wdat[bw+5]); end
    checks++; if (rlen[5] != 16) begin errors++; $display("FAIL to_run_len got %0d want 16", rlen[5]); end
    checks++; if (wdat[bw+6] !== 16'hA006 || rlen[6] != 3) begin errors++; $display("FAIL to_next got %0h len %0d want a006 len 3", wdat[bw+6], rlen[6]); end
    @(negedge clk);
  endtask

  task automatic test_spurious_start();
    int bw, bl, bd; bit ok;
    bw = nw; bl = nl; bd = ndone; stale = 1'b1;
    pulse_start();
    x_origin = 32'h12345678; y_origin = 32'h0BADF00D; step_x = 32'h1; step_y = 32'h1;
    wait_sig(1'b0, ok);
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sp_done_timeout got none want done"); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    stale = 1'b0;
    checks++; if (busy !== 1'b0 || ndone - bd != 1) begin errors++; $display("FAIL sp_ignored busy=%0b dones=%0d want 0/1", busy, ndone - bd); end
    checks++; if (nw - bw != 12) begin errors++; $display("FAIL sp_writes got %0d want 12", nw - bw); end
    checks++; if (cx[bl+4] !== 32'hFE000000 || cy[bl+4] !== 32'h00800000) begin errors++; $display("FAIL sp_origin got %0h/%0h want fe000000/00800000", cx[bl+4], cy[bl+4]); end
    checks++; if (cx[bl+5] !== 32'hFE800000 || cy[bl+11] !== 32'h00000000) begin errors++; $display("FAIL sp_steps got %0h/%0h want fe800000/0", cx[bl+5], cy[bl+11]); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (rlen[i] != 3 || wdat[bw+i] !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL sp_stale%0d got len %0d data %0h want 3/%0h", i, rlen[i], wdat[bw+i], 16'hA000 + 16'(i));
      end
    end
    set_frame();
  endtask

  task automatic test_async_reset();
    int bw; bit ok;
    bw = nw;
    pulse_start();
    wait_writes(bw + 3, ok);
    wait_sig(1'b0, ok);
    #2 rst = 1'b1;
    #1;
    checks++; if (calc_enable !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ar_outputs got en=%0b wr=%0b busy=%0b done=%0b want 0", calc_enable, wr_en, busy, done);
    end
    @(negedge clk); rst = 1'b0; @(negedge clk);
    bw = nw;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || nw - bw != 12) begin errors++; $display("FAIL ar_rescan got %0d writes want 12", nw - bw); end
    checks++; if (wa[bw] !== AW'(0) || wdat[bw] !== 16'hA000 || wa[bw+11] !== AW'(11)) begin
      errors++; $display("FAIL ar_addr got %0h/%0h/%0h want 0/a000/b", wa[bw], wdat[bw], wa[bw+11]);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_write();
    int bw, bd; bit ok;
    bw = nw; bd = ndone;
    pulse_start();
    wait_writes(bw + 2, ok);
    wr_ready = 1'b0;
    wait_sig(1'b1, ok);
    checks++; if (!ok || wr_addr !== AW'(2)) begin errors++; $display("FAIL ab_write got addr %0h want 2", wr_addr); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || calc_enable !== 1'b0) begin
      errors++; $display("FAIL ab_idle got wr=%0b busy=%0b en=%0b want 0", wr_en, busy, calc_enable);
    end
    repeat (5) @(negedge clk);
    checks++; if (ndone != bd || busy !== 1'b0 || nw - bw != 2) begin
      errors++; $display("FAIL ab_quiet got dones=%0d busy=%0b writes=%0d want 0/0/2", ndone - bd, busy, nw - bw);
    end
    wr_ready = 1'b1; bw = nw;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok || nw - bw != 12) begin errors++; $display("FAIL ab_rescan got %0d writes want 12", nw - bw); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (wa[bw+i] !== AW'(i)) begin errors++; $display("FAIL ab_addr%0d got %0h want %0h", i, wa[bw+i], i); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_timeout();
    test_spurious_start();
    test_async_reset();
    test_abort_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
